// File: rtl/cpu_pkg.sv
// Shared CPU types: controller FSM states, the bundled pipeline-register
// control word and the width of the performance counters.
package cpu_pkg;

  localparam int PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the ID instruction reads a register that the load now
// in EX has not produced yet. x0 never creates a dependency.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: load-use bubbles, branch flushes and the
// whole-pipe freeze for slow data-memory accesses, plus perf counters.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  mem_wb_bubble,
  output logic [1:0]            ctrl_state,
  output logic                  mem_err,
  output logic [PERF_CNT_W-1:0] stall_count,
  output logic [PERF_CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_t            state_q, state_d;
  logic [WAIT_W-1:0]      wait_q;
  logic                   mem_err_q;
  logic [PERF_CNT_W-1:0]  stall_count_q, flush_count_q;
  logic                   load_use;
  logic                   freeze;
  pipe_ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // Reset forces a free-running pipe so the pipeline registers can clear themselves.
  always_comb begin
    ctrl    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
                id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};
    state_d = state_q;
    freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) state_d = RUN;
        else            freeze  = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (reset) begin
      freeze  = 1'b0;
      state_d = RUN;
    end else if (freeze) begin
      ctrl.pc_en         = 1'b0;
      ctrl.if_id_en      = 1'b0;
      ctrl.id_ex_en      = 1'b0;
      ctrl.ex_mem_en     = 1'b0;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_ex_flush   = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en         = 1'b0;
      ctrl.if_id_en      = 1'b0;
      ctrl.id_ex_flush   = 1'b1;
    end
  end

  // Wait counter only advances on stalled MEM_WAIT cycles; mem_err is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      wait_q        <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != MEM_WAIT) begin
        wait_q <= '0;
      end else if (!dmem_ready) begin
        if (wait_q != WAIT_MAX) wait_q <= wait_q + WAIT_W'(1);
        if ((int'(wait_q) + 1) >= MEM_TIMEOUT) mem_err_q <= 1'b1;
      end
      if (!ctrl.pc_en && (stall_count_q != CNT_MAX))
        stall_count_q <= stall_count_q + PERF_CNT_W'(1);
      if (ctrl.if_id_flush && (flush_count_q != CNT_MAX))
        flush_count_q <= flush_count_q + PERF_CNT_W'(1);
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign ctrl_state    = state_q;
  assign mem_err       = mem_err_q;
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic        mem_req, dmem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_bubble;
  logic [1:0]  ctrl_state;
  logic        mem_err;
  logic [31:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit     m_in_wait;
  int     m_waits;
  bit     m_err;
  longint m_stalls, m_flushes;

  pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .mem_wb_bubble(mem_wb_bubble), .ctrl_state(ctrl_state), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    set_idle();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble}
  function automatic logic [7:0] model_outputs();
    bit frozen, dependent;
    if (reset) return 8'b1101_0110;
    frozen    = m_in_wait ? !dmem_ready : (mem_req && !dmem_ready);
    dependent = ex_mem_read && ex_rd != 0 &&
                ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (frozen)          return 8'b0000_0011;
    if (ex_branch_taken) return 8'b1111_1110;
    if (dependent)       return 8'b0001_1110;
    return 8'b1101_0110;
  endfunction

  task automatic model_advance(input logic [7:0] outs);
    if (reset) begin
      m_in_wait = 0; m_waits = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if (!outs[7]) m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls  + 1 : CNT_MAX;
    if (outs[5])  m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
    if (!m_in_wait) begin
      if (mem_req && !dmem_ready) begin
        m_in_wait = 1; m_waits = 0;
      end
    end else if (dmem_ready) begin
      m_in_wait = 0;
    end else begin
      if (m_waits < TIMEOUT) m_waits++;
      if (m_waits >= TIMEOUT) m_err = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b11111) begin
      n_fail++; $display("[TB] FAIL reset_enables: got %b expected 11111", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    end
    n_checks++;
    if ({if_id_flush, id_ex_flush, mem_wb_bubble} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flushes: got %b expected 000", {if_id_flush, id_ex_flush, mem_wb_bubble});
    end
    @(negedge clock);
    reset = 1'b0;
    set_idle();
    #1;
    n_checks++;
    if (ctrl_state !== 2'd0 || mem_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_state: got state=%0d err=%b expected 0/0", ctrl_state, mem_err);
    end
    n_checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_flush, id_ex_en, ex_mem_en, if_id_flush} !== 6'b001110) begin
      n_fail++; $display("[TB] FAIL load_use_bubble: got %b expected 001110",
                         {pc_en, if_id_en, id_ex_flush, id_ex_en, ex_mem_en, if_id_flush});
    end
    @(negedge clock);
    ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_flush} !== 3'b110) begin
      n_fail++; $display("[TB] FAIL load_use_release: got %b expected 110", {pc_en, if_id_en, id_ex_flush});
    end
    n_checks++;
    if (stall_count !== 32'd1) begin
      n_fail++; $display("[TB] FAIL load_use_stall_count: got %0d expected 1", stall_count);
    end
    // rs2 path
    id_uses_rs1 = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    #1;
    n_checks++;
    if (pc_en !== 1'b0 || id_ex_flush !== 1'b1) begin
      n_fail++; $display("[TB] FAIL load_use_rs2: got pc_en=%b flush=%b expected 0/1", pc_en, id_ex_flush);
    end
  endtask

  task automatic test_x0_immunity();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    n_checks++;
    if (pc_en !== 1'b1 || id_ex_flush !== 1'b0) begin
      n_fail++; $display("[TB] FAIL x0_no_stall: got pc_en=%b flush=%b expected 1/0", pc_en, id_ex_flush);
    end
    @(negedge clock);
    set_idle();
    #1;
    n_checks++;
    if (stall_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL x0_stall_count: got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({if_id_flush, id_ex_flush, pc_en, if_id_en, id_ex_en} !== 5'b11111) begin
      n_fail++; $display("[TB] FAIL branch_flush: got %b expected 11111",
                         {if_id_flush, id_ex_flush, pc_en, if_id_en, id_ex_en});
    end
    @(negedge clock);
    set_idle();
    #1;
    n_checks++;
    if (flush_count !== 32'd1 || stall_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL branch_counters: got flush=%0d stall=%0d expected 1/0", flush_count, stall_count);
    end
  endtask

  task automatic test_mem_hit();
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (pc_en !== 1'b1 || mem_wb_bubble !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mem_hit_no_freeze: got pc_en=%b bubble=%b expected 1/0", pc_en, mem_wb_bubble);
    end
    @(negedge clock);
    set_idle();
    #1;
    n_checks++;
    if (ctrl_state !== 2'd0 || stall_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL mem_hit_state: got state=%0d stall=%0d expected 0/0", ctrl_state, stall_count);
    end
  endtask

  task automatic test_mem_wait();
    bit frz;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clock);
      mem_req = 1'b1; dmem_ready = (i == 3);
      frz = (i < 3);
      #1;
      n_checks++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, mem_wb_bubble} !== {{4{!frz}}, 1'b1, frz}) begin
        n_fail++; $display("[TB] FAIL mem_wait_outputs[%0d]: got %b expected %b", i,
                           {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, mem_wb_bubble}, {{4{!frz}}, 1'b1, frz});
      end
      n_checks++;
      if (ctrl_state !== ((i == 0) ? 2'd0 : 2'd1)) begin
        n_fail++; $display("[TB] FAIL mem_wait_state[%0d]: got %0d expected %0d", i, ctrl_state, (i == 0) ? 0 : 1);
      end
    end
    @(negedge clock);
    set_idle();
    #1;
    n_checks++;
    if (ctrl_state !== 2'd0 || stall_count !== 32'd3) begin
      n_fail++; $display("[TB] FAIL mem_wait_done: got state=%0d stall=%0d expected 0/3", ctrl_state, stall_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if (mem_err !== ((j - 1) >= TIMEOUT) || ctrl_state !== 2'd1) begin
        n_fail++; $display("[TB] FAIL timeout_err[%0d]: got err=%b state=%0d expected %b/1",
                           j, mem_err, ctrl_state, ((j - 1) >= TIMEOUT));
      end
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (pc_en !== 1'b1 || mem_wb_bubble !== 1'b0) begin
      n_fail++; $display("[TB] FAIL timeout_reset_outputs: got pc_en=%b bubble=%b expected 1/0", pc_en, mem_wb_bubble);
    end
    @(negedge clock);
    reset = 1'b0;
    set_idle();
    #1;
    n_checks++;
    if ({ctrl_state, mem_err} !== 3'b000 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL timeout_after_reset: got state=%0d err=%b stall=%0d flush=%0d expected 0/0/0/0",
                         ctrl_state, mem_err, stall_count, flush_count);
    end
  endtask

  task automatic test_saturation();
    longint exp_stalls;
    do_reset();
    @(negedge clock);
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    exp_stalls = 64'hFFFF_FFFE;
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      exp_stalls = (exp_stalls < CNT_MAX) ? exp_stalls + 1 : CNT_MAX;
      #1;
      n_checks++;
      if (stall_count !== exp_stalls[31:0]) begin
        n_fail++; $display("[TB] FAIL saturation[%0d]: got %h expected %h", k, stall_count, exp_stalls[31:0]);
      end
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [7:0] exp;
    do_reset();
    m_in_wait = 0; m_waits = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      reset           = ($urandom_range(0, 59) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      dmem_ready      = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      exp = model_outputs();
      n_checks++;
      if ({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble} !== exp) begin
        n_fail++; $display("[TB] FAIL random_ctrl[%0d]: got %b expected %b", c,
                           {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble}, exp);
      end
      n_checks++;
      if (ctrl_state !== (m_in_wait ? 2'd1 : 2'd0) || mem_err !== m_err) begin
        n_fail++; $display("[TB] FAIL random_state[%0d]: got state=%0d err=%b expected %0d/%b",
                           c, ctrl_state, mem_err, m_in_wait ? 1 : 0, m_err);
      end
      n_checks++;
      if (stall_count !== m_stalls[31:0] || flush_count !== m_flushes[31:0]) begin
        n_fail++; $display("[TB] FAIL random_counters[%0d]: got %0d/%0d expected %0d/%0d",
                           c, stall_count, flush_count, m_stalls, m_flushes);
      end
      model_advance(exp);
    end
    @(negedge clock);
    reset = 1'b0;
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_x0_immunity();
    test_branch_vs_load_use();
    test_mem_hit();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage RV32 pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards:
- load-use data hazards, by inserting a one-cycle bubble;
- taken branches/jumps resolved in EX, by a two-stage flush;
- multi-cycle data-memory accesses, by a whole-pipe freeze with a timeout.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum number of cycles spent in MEM_WAIT before mem_err is set.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect)
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads zero (NOP)
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads zero control (bubble)
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- mem_wb_bubble  out  1  MEM/WB loads zero control
- ctrl_state  out  2  current FSM state (debug)
- mem_err  out  1  sticky: memory wait exceeded MEM_TIMEOUT
- stall_count  out  32  cycles with pc_en=0
- flush_count  out  32  branch flush events

## Operation
**FSM states:** RUN, MEM_WAIT.

**RUN**
- If mem_req && !dmem_ready: go to MEM_WAIT. This cycle is already a freeze cycle.
- Otherwise apply, in priority order:
  1. **Branch:** ex_branch_taken → if_id_flush=1, id_ex_flush=1, all enables=1. Any load-use condition is ignored because the younger instruction is flushed.
  2. **Load-use:** ex_mem_read && ex_rd≠0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)) → pc_en=0, if_id_en=0, id_ex_flush=1. All other enables=1.
  3. **Default:** all enables=1, all flushes=0.

**Freeze** (the RUN entry cycle and every MEM_WAIT cycle without dmem_ready)
- pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
- mem_wb_en=1 with mem_wb_bubble=1, so WB does not retire the same instruction twice.
- Branch and load-use conditions are held by the frozen stages and act once the pipe advances.

**MEM_WAIT**
- Freeze while dmem_ready=0.
- On dmem_ready=1: outputs as in RUN (branch/load-use priority applies), then go to RUN.
- A wait counter counts MEM_WAIT cycles, resets on entry, and saturates. When it reaches MEM_TIMEOUT, mem_err is set sticky and the FSM stays in MEM_WAIT.

**Counters**
- stall_count increments on every cycle with pc_en=0.
- flush_count increments on every cycle with if_id_flush=1.
- Both are 32-bit and saturate at 0xFFFF_FFFF.

## Timing
- All pipeline-control outputs are combinational from the current state and inputs, with zero latency, so registers act on the same clock edge.
- ctrl_state, mem_err and the counters are registered and update on the next edge.
- **During reset:** all enables=1, flushes=0, bubble=0. Pipeline registers clear themselves.
- **Registered values after reset:** ctrl_state=RUN(0), mem_err=0, stall_count=0, flush_count=0, wait counter=0.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN on the next edge, regardless of dmem_ready.
- Load-use always costs exactly 1 stall cycle; on the next cycle the load is in MEM, so no condition remains.
- A taken branch costs 2 flushed slots.
- mem_req && dmem_ready in the same RUN cycle costs no stall.

## Structure
- cpu_pkg gains:
  - ctrl_state_t enum (RUN=0, MEM_WAIT=1);
  - pipe_ctrl_t packed struct bundling the 8 enable/flush/bubble signals, so pipeline registers can take one port;
  - localparam PERF_CNT_W=32.
- Sub-module hazard_detect: combinational load-use compare that outputs load_use. It is instantiated once here.
- Pipeline registers gain en and flush inputs: flush has priority over en.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → for one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle (ex_mem_read=0) all enables=1. stall_count=1.
- **x0 immunity:** same as load-use but ex_rd=0 and id_rs1=0 → no stall. stall_count stays 0.
- **Branch vs load-use:** ex_branch_taken=1 with the load-use condition also true → if_id_flush=1, id_ex_flush=1, pc_en=1. flush_count=1, stall_count=0.
- **Memory wait:** mem_req=1 with dmem_ready low for 3 cycles, then high → 3 freeze cycles with mem_wb_bubble=1, ctrl_state=MEM_WAIT for cycles 2–3, RUN after the ready edge. stall_count=3.
- **Timeout:** MEM_TIMEOUT=4 and dmem_ready held 0 → mem_err=1 after the 4th MEM_WAIT cycle and it stays 1 until reset. Then reset mid-wait → ctrl_state=RUN, counters=0.
- **Saturation:** force stall_count to 0xFFFF_FFFE, then apply 3 stall cycles → reads 0xFFFF_FFFF.
